// File: rtl/conv_mmio_responder.sv
// MMIO responder with a 3x3 signed MAC engine on the core data bus.
// Optional build macro: CONV_RELU_EN clamps negative results to zero.
module conv_mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        done_irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [5:0] A_CTRL = 6'd32;
  localparam logic [5:0] A_STAT = 6'd33;
  localparam logic [5:0] A_RES  = 6'd34;
  localparam logic [5:0] A_BIAS = 6'd35;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [31:0] acc;
  logic [31:0] result;
  logic [31:0] bias;
  logic [31:0] w [9];
  logic [31:0] x [9];
  logic        done;

  logic        hit;
  logic        take;
  logic [5:0]  word;
  logic        is_w;
  logic        is_x;
  logic        start;
  logic [31:0] rdata;
  logic [31:0] wk;
  logic [31:0] xk;
  logic [31:0] prod;
  logic [31:0] res;
  logic [31:0] res_out;

  assign req_ready = ~rst;
  assign busy      = (state != S_IDLE);

  assign hit   = (req_addr[31:8] == BASE_ADDR[31:8]);
  assign take  = req_valid & hit & ~rst;
  assign word  = req_addr[7:2];
  assign is_w  = (word[5:4] == 2'b00) && (word[3:0] <= 4'd8);
  assign is_x  = (word[5:4] == 2'b01) && (word[3:0] <= 4'd8);
  assign start = take & req_we & (word == A_CTRL)
               & req_wdata[0] & ~busy;

  // Sign-extend the low halves; the low 32 bits of the product are exact.
  assign wk   = {{16{w[idx][15]}}, w[idx][15:0]};
  assign xk   = {{16{x[idx][15]}}, x[idx][15:0]};
  assign prod = wk * xk;
  assign res  = acc + bias;

`ifdef CONV_RELU_EN
  assign res_out = res[31] ? 32'd0 : res;
`else
  assign res_out = res;
`endif

  always_comb begin
    rdata = 32'd0;
    unique case (1'b1)
      is_w:             rdata = w[word[3:0]];
      is_x:             rdata = x[word[3:0]];
      (word == A_STAT): rdata = {30'd0, done, busy};
      (word == A_RES):  rdata = result;
      (word == A_BIAS): rdata = bias;
      default:          rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      acc       <= 32'd0;
      result    <= 32'd0;
      bias      <= 32'd0;
      done      <= 1'b0;
      done_irq  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      for (int i = 0; i < 9; i++) begin
        w[i] <= 32'd0;
        x[i] <= 32'd0;
      end
    end else begin
      rsp_valid <= take;
      rsp_rdata <= (take && !req_we) ? rdata : 32'd0;
      done_irq  <= 1'b0;

      if (take && !req_we && word == A_STAT)
        done <= 1'b0;

      if (take && req_we && !busy) begin
        if (is_w) w[word[3:0]] <= req_wdata;
        if (is_x) x[word[3:0]] <= req_wdata;
        if (word == A_BIAS) bias <= req_wdata;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= 32'd0;
            idx   <= 4'd0;
            done  <= 1'b0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          idx <= idx + 4'd1;
          if (idx == 4'd8) state <= S_FIN;
        end
        S_FIN: begin
          // A same-cycle STATUS read clear is overridden here.
          result   <= res_out;
          done     <= 1'b1;
          done_irq <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mmio_responder.sv
// Scoreboard bench for conv_mmio_responder with a register-level model.
// Build with CONV_RELU_EN defined to check the clamped variant.
module tb_conv_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        done_irq;

  conv_mmio_responder #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy(busy),
    .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  logic [31:0] mw [9];
  logic [31:0] mx [9];
  logic [31:0] mbias = 32'd0;
  logic [31:0] mres = 32'd0;
  logic [31:0] pres = 32'd0;
  bit          mdone = 1'b0;
  bit          pend = 1'b0;
  int          fin_e = 0;
  int          irq_e = -1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h want %h", name, edge_n, act, exp);
    end
  endtask

  // Kernel result straight from the arithmetic rules.
  function automatic logic [31:0] kernel();
    logic [31:0] s;
    int a, b;
    s = mbias;
    for (int i = 0; i < 9; i++) begin
      a = int'($signed(mw[i][15:0]));
      b = int'($signed(mx[i][15:0]));
      s = s + 32'(a * b);
    end
`ifdef CONV_RELU_EN
    if ($signed(s) < 0) s = 32'd0;
`endif
    return s;
  endfunction

  function automatic logic [31:0] mread(logic [7:0] off, bit bsy);
    if (off <= 8'h20) return mw[off / 4];
    if (off >= 8'h40 && off <= 8'h60) return mx[(off - 8'h40) / 4];
    if (off == 8'h84) return {30'd0, mdone, bsy};
    if (off == 8'h88) return mres;
    if (off == 8'h8C) return mbias;
    return 32'd0;
  endfunction

  // Reference model, advanced once per rising edge.
  initial begin
    bit hit, bsy;
    logic [7:0] off;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      mw[i] = 32'd0;
      mx[i] = 32'd0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        for (int i = 0; i < 9; i++) begin
          mw[i] = 32'd0;
          mx[i] = 32'd0;
        end
        mbias = 0; mres = 0; mdone = 0; pend = 0; irq_e = -1;
        q.delete();
      end else begin
        hit = req_valid && (req_addr[31:8] == BASE[31:8]);
        off = {req_addr[7:2], 2'b00};
        bsy = pend;
        if (hit) begin
          e.due  = edge_n;
          e.data = req_we ? 32'd0 : mread(off, bsy);
          q.push_back(e);
          if (!req_we && off == 8'h84) mdone = 0;
        end
        if (pend && edge_n == fin_e) begin
          mres = pres; mdone = 1; irq_e = edge_n; pend = 0;
        end
        if (hit && req_we && !bsy) begin
          if (off <= 8'h20) mw[off / 4] = req_wdata;
          else if (off >= 8'h40 && off <= 8'h60)
            mx[(off - 8'h40) / 4] = req_wdata;
          else if (off == 8'h8C) mbias = req_wdata;
          else if (off == 8'h80 && req_wdata[0]) begin
            pres = kernel();
            mdone = 0; pend = 1; fin_e = edge_n + 10;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model between edges.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("ready", {31'd0, req_ready}, {31'd0, !rst});
      if (q.size() > 0 && q[0].due == edge_n) begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, q[0].data);
        void'(q.pop_front());
      end else begin
        chk("no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      chk("busy", {31'd0, busy}, {31'd0, pend});
      chk("done_irq", {31'd0, done_irq}, {31'd0, irq_e == edge_n});
    end
  end

  task automatic put(bit we, logic [31:0] a, logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_w(int i, logic [31:0] d);
    put(1, BASE + 32'(4 * i), d);
  endtask

  task automatic wr_x(int i, logic [31:0] d);
    put(1, BASE + 32'h40 + 32'(4 * i), d);
  endtask

  task automatic rd(logic [7:0] off);
    put(0, BASE + {24'd0, off}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Basic sum
    for (int i = 0; i < 9; i++) wr_w(i, 1);
    for (int i = 0; i < 9; i++) wr_x(i, 32'(i + 1));
    put(1, BASE + 32'h8C, 0);
    put(1, BASE + 32'h80, 1);
    idle(12);
    rd(8'h88); rd(8'h84); rd(8'h84);

    // Signed product with positive bias
    for (int i = 0; i < 9; i++) begin
      wr_w(i, 0); wr_x(i, 0);
    end
    wr_w(0, 32'hFFFF_FFFD); wr_x(0, 5);
    put(1, BASE + 32'h8C, 2);
    put(1, BASE + 32'h80, 1);
    idle(12);
    rd(8'h88);

    // Wrap-around accumulation
    for (int i = 0; i < 9; i++) begin
      wr_w(i, 32'h7FFF); wr_x(i, 32'h7FFF);
    end
    put(1, BASE + 32'h8C, 0);
    put(1, BASE + 32'h80, 1);
    idle(12);
    rd(8'h88);

    // Writes while busy are dropped
    put(1, BASE + 32'h80, 1);
    wr_x(0, 100);
    put(1, BASE + 32'h80, 1);
    idle(12);
    rd(8'h40); rd(8'h84);

    // STATUS read on the FIN edge
    put(1, BASE + 32'h80, 1);
    idle(9);
    rd(8'h84); rd(8'h84); rd(8'h84);

    // Reset in the middle of a run
    put(1, BASE + 32'h80, 1);
    idle(3);
    rst = 1'b1;
    put(0, BASE + 32'h88, 0);
    rst = 1'b0;
    idle(12);
    rd(8'h88); rd(8'h00); rd(8'h40); rd(8'h60);

    // Decode and back-to-back throughput
    rd(8'h90);
    put(1, BASE + 32'h90, 32'hDEAD_BEEF);
    put(1, BASE + 32'h100, 32'h1234);
    rd(8'h90);
    put(0, BASE + 32'h100, 0);
    wr_w(3, 32'hCAFE_0007);
    put(0, BASE + 32'h0E, 0);
    put(1, BASE + 32'h8F, 32'h55);
    rd(8'h8C);
    idle(2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end else if ($urandom_range(19) == 0) begin
        idle($urandom_range(4, 1));
      end else begin
        if ($urandom_range(19) == 0)
          a = {$urandom_range(255) == 0 ? 24'h0 : 24'h11, 8'($urandom)};
        else
          a = BASE + 32'($urandom_range(255));
        if ($urandom_range(14) == 0)
          put(1, BASE + 32'h80, 32'($urandom_range(3)));
        else if ($urandom_range(1) == 0)
          put(1, a, $urandom_range(1) ? $urandom : 32'($urandom_range(40)) - 20);
        else
          put(0, a, 32'd0);
      end
    end
    idle(14);

    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
